// File: rtl/gcd_ctrl_if.sv
// Operand/result handshake bundle between the GCD controller and its producer/consumer.
// The slave side is the controller; the master side supplies operands and takes results.
interface gcd_ctrl_if #(
  parameter int W  = 32,
  parameter int CW = 10
);
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  xin;
  logic [W-1:0]  yin;
  logic          done_valid;
  logic          done_ready;
  logic [1:0]    err;
  logic [CW-1:0] steps;

  modport master (
    output start_valid, xin, yin, done_ready,
    input  start_ready, done_valid, err, steps
  );

  modport slave (
    input  start_valid, xin, yin, done_ready,
    output start_ready, done_valid, err, steps
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Euclid-by-subtraction sequencer for gcd_datapath; result valid steps+4 cycles after accept (1 for zero operand).
// Accepts only in IDLE; holds done_valid/err/steps in DONE until done_ready.
module gcd_ctrl #(
  parameter int W        = 32,
  parameter int MAX_ITER = 1023,
  parameter int CW       = 10
) (
  input  logic        clk,
  input  logic        clr_n,
  gcd_ctrl_if.slave   bus,
  input  logic        eqflg,
  input  logic        ltflg,
  output logic        xmsel,
  output logic        ymsel,
  output logic        xld,
  output logic        yld,
  output logic        gld,
  output logic        dp_clr,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LP_MAX = CW'(MAX_ITER);

  state_t        r_state;
  state_t        w_nxt;
  logic [1:0]    r_err;
  logic [CW-1:0] r_steps;
  logic          w_accept;
  logic          w_zero;
  logic          w_at_max;
  logic          w_start_ready;

  assign w_zero   = (bus.xin == '0) || (bus.yin == '0);
  assign w_at_max = (r_steps == LP_MAX);
  assign w_accept = bus.start_valid && w_start_ready;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_err   <= 2'b00;
      r_steps <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_steps <= '0;
        r_err   <= w_zero ? 2'b01 : 2'b00;
      end else if (r_state == S_CALC && !eqflg) begin
        if (w_at_max) r_err <= 2'b10;
        else          r_steps <= r_steps + 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nxt = w_zero ? S_DONE : S_LOAD;
      S_LOAD:  w_nxt = S_CALC;
      S_CALC: begin
        if (eqflg)         w_nxt = S_STORE;
        else if (w_at_max) w_nxt = S_DONE;
      end
      S_STORE: w_nxt = S_DONE;
      S_DONE:  if (bus.done_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Flag-driven subtract choice is Mealy: decided from this cycle's eqflg/ltflg.
  always_comb begin
    w_start_ready  = 1'b0;
    xmsel          = 1'b0;
    ymsel          = 1'b0;
    xld            = 1'b0;
    yld            = 1'b0;
    gld            = 1'b0;
    bus.done_valid = 1'b0;
    case (r_state)
      S_IDLE: w_start_ready = 1'b1;
      S_LOAD: begin
        xmsel = 1'b1;
        ymsel = 1'b1;
        xld   = 1'b1;
        yld   = 1'b1;
      end
      S_CALC: begin
        if (!eqflg && !w_at_max) begin
          if (ltflg) yld = 1'b1;
          else       xld = 1'b1;
        end
      end
      S_STORE: gld = 1'b1;
      S_DONE:  bus.done_valid = 1'b1;
      default: ;
    endcase
    // A reset edge must never commit a load or present a result.
    if (!clr_n) begin
      xld            = 1'b0;
      yld            = 1'b0;
      gld            = 1'b0;
      bus.done_valid = 1'b0;
    end
  end

  assign bus.start_ready = w_start_ready;
  assign bus.err         = r_err;
  assign bus.steps       = r_steps;
  assign busy            = (r_state != S_IDLE);
  assign dp_clr          = ~clr_n;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl with a behavioural subtract datapath beside it.
module tb_gcd_ctrl;
  localparam int W        = 16;
  localparam int CW       = 4;
  localparam int MAX_ITER = 8;

  logic clk = 1'b0;
  logic clr_n;
  logic eqflg, ltflg, xmsel, ymsel, xld, yld, gld, dp_clr, busy;

  gcd_ctrl_if #(.W(W), .CW(CW)) bus ();

  gcd_ctrl #(.W(W), .MAX_ITER(MAX_ITER), .CW(CW)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .bus    (bus.slave),
    .eqflg  (eqflg),
    .ltflg  (ltflg),
    .xmsel  (xmsel),
    .ymsel  (ymsel),
    .xld    (xld),
    .yld    (yld),
    .gld    (gld),
    .dp_clr (dp_clr),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] dx, dy, dg;
  always @(posedge clk) begin
    if (dp_clr) begin
      dx <= '0;
      dy <= '0;
      dg <= '0;
    end else begin
      if (xld) dx <= xmsel ? bus.xin : dx - dy;
      if (yld) dy <= ymsel ? bus.yin : dy - dx;
      if (gld) dg <= dx;
    end
  end
  assign eqflg = (dx == dy);
  assign ltflg = (dx < dy);

  typedef struct {
    int err;
    int steps;
    int gcd;
    int lat;
    int xs;
    int ys;
    int ld;
    int gl;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int xs_cnt = 0, ys_cnt = 0, ld_cnt = 0, gl_cnt = 0;
  int gld_total = 0, done_total = 0;
  bit seen_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: tracks pulses per transaction and compares against the queue head.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (gld) gld_total++;
    if (clr_n) begin
      if (bus.start_valid && bus.start_ready) begin
        acc_cyc   = cyc;
        xs_cnt    = 0;
        ys_cnt    = 0;
        ld_cnt    = 0;
        gl_cnt    = 0;
        seen_done = 1'b0;
      end
      if (xld && !xmsel) xs_cnt++;
      if (yld && !ymsel) ys_cnt++;
      if (xld && xmsel && yld && ymsel) ld_cnt++;
      if (gld) gl_cnt++;
      if (bus.done_valid) begin
        done_total++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q[0];
          chk("err", int'(bus.err), e.err);
          chk("steps", int'(bus.steps), e.steps);
          if (!seen_done) chk("latency", cyc - acc_cyc, e.lat);
          seen_done = 1'b1;
          if (bus.done_ready) begin
            e = q.pop_front();
            chk("gcd", int'(dg), e.gcd);
            chk("x_sub_pulses", xs_cnt, e.xs);
            chk("y_sub_pulses", ys_cnt, e.ys);
            chk("load_pulses", ld_cnt, e.ld);
            chk("gld_pulses", gl_cnt, e.gl);
            seen_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic run(input int x, input int y, input int e_err, input int e_steps,
                     input int e_gcd, input int e_lat, input int e_xs, input int e_ys,
                     input int e_ld, input int e_gl, input int hold, input bit poke,
                     input bit push);
    exp_t e;
    int n;
    e = '{e_err, e_steps, e_gcd, e_lat, e_xs, e_ys, e_ld, e_gl};
    @(posedge clk); #1;
    if (push) q.push_back(e);
    bus.start_valid = 1'b1;
    bus.xin         = W'(x);
    bus.yin         = W'(y);
    bus.done_ready  = (hold == 0);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      bus.start_valid = 1'b1;
      bus.xin         = W'(3);
      bus.yin         = W'(3);
      @(negedge clk);
      chk("ready_while_busy", int'(bus.start_ready), 0);
      @(posedge clk); #1;
      bus.start_valid = 1'b0;
    end
    if (!push) return;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done_valid && n < 200);
    if (!bus.done_valid) begin
      chk("done_timeout", 0, 1);
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("held_valid", int'(bus.done_valid), 1);
      @(posedge clk); #1;
      bus.done_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("ready_after_done", int'(bus.start_ready), 1);
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    int g0, d0;
    clr_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.xin         = '0;
    bus.yin         = '0;
    bus.done_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dp_clr", int'(dp_clr), 1);
    chk("rst_start_ready", int'(bus.start_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_valid", int'(bus.done_valid), 0);
    chk("rst_loads", int'({xmsel, ymsel, xld, yld, gld}), 0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("run_dp_clr", int'(dp_clr), 0);

    //  x   y  err st gcd lat xs ys ld gl hold poke push
    run(12, 18, 0, 2, 6,  6, 1, 1, 1, 1, 0, 0, 1);
    run(7,  7,  0, 0, 7,  4, 0, 0, 1, 1, 0, 0, 1);
    run(1,  9,  0, 8, 1, 12, 0, 8, 1, 1, 0, 0, 1);
    run(0,  5,  1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1);
    run(5,  0,  1, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1);
    run(1,  20, 2, 8, 1, 11, 0, 8, 1, 0, 0, 0, 1);
    run(12, 18, 0, 2, 6,  6, 1, 1, 1, 1, 5, 1, 1);

    g0 = gld_total;
    d0 = done_total;
    run(1, 500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_in_calc", int'(busy), 1);
    clr_n = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", int'(busy), 0);
    chk("abort_ready", int'(bus.start_ready), 1);
    repeat (15) @(negedge clk);
    chk("abort_no_gld", gld_total, g0);
    chk("abort_no_done", done_total, d0);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
- FSM controller that sequences gcd_datapath (mux selects, register loads, clear) from the datapath's eqflg/ltflg flags.
- Runs Euclid by subtraction, one subtract step per clock.
- Upstream side: start/ready operand handshake. Downstream side: done/ready result handshake carrying an error code and a step count.
- Instantiated beside gcd_datapath in the GCD top. xin/yin fan out to both blocks.

Parameters:
- W, 32, operand width; must match the datapath xin/yin width.
- MAX_ITER, 1023, maximum subtract steps before a timeout abort.
- CW, 10, step-counter width; must satisfy 2^CW > MAX_ITER.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr_n  in  1  synchronous reset, active-low.
- start_valid  in  1  operands on xin/yin are valid.
- start_ready  out  1  controller is able to accept operands.
- xin  in  W  operand A; used only for zero check.
- yin  in  W  operand B; used only for zero check.
- eqflg  in  1  datapath x==y.
- ltflg  in  1  datapath x<y.
- xmsel  out  1  datapath x-mux select (1 = xin).
- ymsel  out  1  datapath y-mux select (1 = yin).
- xld  out  1  datapath x register load.
- yld  out  1  datapath y register load.
- gld  out  1  datapath gcd register load.
- dp_clr  out  1  datapath clear, active-high.
- busy  out  1  a computation is in progress (state not IDLE).
- done_valid  out  1  result status is valid.
- done_ready  in  1  consumer accepts the result status.
- err  out  2  00 ok, 01 zero operand, 10 timeout.
- steps  out  CW  number of subtract steps performed.

Behaviour:
- Reset: synchronous, active-low. While clr_n=0 at a rising edge, state<=IDLE, err<=0, steps<=0.
- dp_clr = ~clr_n (combinational), so the datapath clears on the same edge.
- Outputs after reset: start_ready=1, busy=0, done_valid=0, xmsel=ymsel=xld=yld=gld=0.
- Reset mid-operation aborts immediately, with no gld and no done_valid.
- States: IDLE, LOAD, CALC, STORE, DONE.
- Accept rule: accept occurs when start_valid & start_ready (start_ready=1 only in IDLE).
  - On accept, steps<=0.
  - If xin==0 or yin==0: err<=01, go to DONE. No datapath loads and no gld; gcd register keeps its old value.
  - Otherwise: err<=00, go to LOAD.
- Operand hold: xin/yin must remain stable from the accept cycle through the LOAD cycle. The top holds them while busy.
- LOAD: xmsel=ymsel=1, xld=yld=1. Go to CALC.
- CALC (Mealy outputs, decided from flags in the current cycle), priority top to bottom:
  - eqflg=1: go to STORE.
  - else steps==MAX_ITER: err<=10, go to DONE; no load this cycle.
  - else ltflg=1: ymsel=0, yld=1 (y<=y-x), steps<=steps+1, stay in CALC.
  - else: xmsel=0, xld=1 (x<=x-y), steps<=steps+1, stay in CALC.
- STORE: gld=1 (gcd<=x). Go to DONE.
- DONE: done_valid=1; err and steps held stable.
  - done_ready=1: go to IDLE next cycle.
  - done_ready=0: stay in DONE indefinitely.
- Back-to-back operation: start_ready rises the cycle after the DONE handshake, so a new accept can occur no earlier than that.
- Outputs not named in a state are 0 in that state. xmsel/ymsel default to 0.
- Latency, OK path: done_valid is asserted at cycle steps+4, counting the accept cycle as cycle 0.
  - Cycle 1 LOAD, cycles 2..steps+1 CALC subtracts, cycle steps+2 CALC sees eqflg, cycle steps+3 STORE, cycle steps+4 DONE.
- Latency, zero path: done_valid at cycle 1.
- Latency, timeout path: done_valid at cycle MAX_ITER+3, with steps=MAX_ITER.
- start_valid while busy is ignored and not queued; start_ready=0.
- steps never exceeds MAX_ITER; no wrap.
- done_ready outside DONE has no effect.

Test Plan:
- Reset / mid-operation abort: hold clr_n=0 for 2 cycles -> dp_clr=1, start_ready=1, busy=0, done_valid=0, all loads 0. Then, mid-CALC of (1,500), pull clr_n=0 for 1 cycle -> IDLE next cycle, gld never pulses, done_valid stays 0.
- Nominal: xin=12, yin=18, done_ready=1 -> one yld step then one xld step; gld at cycle 5; done_valid at cycle 6 with err=00, steps=2; datapath gcd=6; start_ready=1 at cycle 7.
- Equal and coprime operands: (7,7) -> steps=0, done_valid at cycle 4, gcd=7. (1,9) -> steps=8, gcd=1, exactly 8 yld pulses.
- Zero operand: (0,5) and separately (5,0) -> done_valid at cycle 1, err=01, steps=0, no xld/yld/gld pulse, gcd register unchanged.
- Timeout: MAX_ITER=8, (1,20) -> exactly 8 yld pulses, err=10, steps=8, done_valid at cycle 11, gld never pulses.
- Backpressure / busy: done_ready=0 for 5 cycles in DONE -> done_valid, err, steps held stable. start_valid pulsed during CALC -> not accepted; datapath x/y undisturbed.
